// File: rtl/lc3_io_pkg.sv
// Shared LC3 memory-mapped I/O definitions: console addresses,
// transmitter state encoding and the DSR word layout.
package lc3_io_pkg;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_e;

    localparam logic [15:0] LC3_ADDR_DSR = 16'hFE04;
    localparam logic [15:0] LC3_ADDR_DDR = 16'hFE06;

    function automatic logic [15:0] dsr_word(input logic ready, input logic ie);
        return {ready, ie, 14'b0};
    endfunction

endpackage

// File: rtl/uart_tx.sv
// 8N1 serial transmitter: start bit, 8 data bits LSB first, stop bit.
// o_Done is high during the last cycle of the stop bit.
module uart_tx
    import lc3_io_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       i_CLK,
    input  logic       i_Reset,
    input  logic       i_Start,
    input  logic [7:0] i_Byte,
    output logic       o_TX,
    output logic       o_Done
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);

    tx_state_e     state_q;
    logic [CW-1:0] cnt_q;
    logic [2:0]    idx_q;
    logic [7:0]    shift_q;
    logic          tx_q;
    logic          bit_end;

    assign bit_end = (cnt_q == CNT_MAX);
    assign o_Done  = (state_q == TX_STOP) && bit_end;
    assign o_TX    = tx_q;

    always_ff @(posedge i_CLK) begin
        if (i_Reset) begin
            state_q <= TX_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            unique case (state_q)
                TX_IDLE: begin
                    if (i_Start) begin
                        state_q <= TX_START;
                        shift_q <= i_Byte;
                        cnt_q   <= '0;
                        tx_q    <= 1'b0;
                    end
                end
                TX_START: begin
                    if (bit_end) begin
                        cnt_q   <= '0;
                        state_q <= TX_DATA;
                        tx_q    <= shift_q[0];
                        shift_q <= {1'b0, shift_q[7:1]};
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                TX_DATA: begin
                    if (bit_end) begin
                        cnt_q <= '0;
                        // index wraps 7 -> 0 as the frame leaves DATA
                        idx_q <= idx_q + 1'b1;
                        if (idx_q == 3'd7) begin
                            state_q <= TX_STOP;
                            tx_q    <= 1'b1;
                        end else begin
                            tx_q    <= shift_q[0];
                            shift_q <= {1'b0, shift_q[7:1]};
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                TX_STOP: begin
                    if (bit_end) begin
                        cnt_q   <= '0;
                        state_q <= TX_IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= TX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/lc3_console_tx.sv
// LC3 console display (DSR/DDR) with serial output; define
// LC3_CONSOLE_IE_EN for a writable DSR IE bit and the o_INT request.
module lc3_console_tx
    import lc3_io_pkg::*;
#(
    parameter int          CLKS_PER_BIT = 868,
    parameter logic [15:0] ADDR_DSR     = LC3_ADDR_DSR,
    parameter logic [15:0] ADDR_DDR     = LC3_ADDR_DDR
) (
    input  logic        i_CLK,
    input  logic        i_Reset,
    input  logic        i_MIO_EN,
    input  logic        i_R_W,
    input  logic [15:0] i_MAR,
    input  logic [15:0] i_MDR,
    output logic [15:0] o_Data,
    output logic        o_Ready,
    output logic        o_Hit,
    output logic        o_TX,
    output logic        o_INT
);

    logic        sel_dsr;
    logic        sel_ddr;
    logic        access;
    logic        start;
    logic        tx_done;
    logic        rdy_q, rdy_d;
    logic        ie_q, ie_d;
    logic        ack_q;
    logic [7:0]  ddr_q, ddr_d;
    logic [15:0] data_q, data_d;
    logic        unused_mdr;

    assign sel_dsr    = (i_MAR == ADDR_DSR);
    assign sel_ddr    = (i_MAR == ADDR_DDR);
    assign o_Hit      = sel_dsr | sel_ddr;
    assign access     = i_MIO_EN & o_Hit;
    assign unused_mdr = ^i_MDR[15:8];

    // acceptance looks only at the registered flag
    assign start = access & i_R_W & sel_ddr & rdy_q;

    always_comb begin
        rdy_d  = rdy_q;
        ie_d   = ie_q;
        ddr_d  = ddr_q;
        data_d = '0;
        if (tx_done) begin
            rdy_d = 1'b1;
        end else if (start) begin
            rdy_d = 1'b0;
        end
        if (start) begin
            ddr_d = i_MDR[7:0];
        end
`ifdef LC3_CONSOLE_IE_EN
        if (access & i_R_W & sel_dsr) begin
            ie_d = i_MDR[14];
        end
`endif
        if (access & ~i_R_W) begin
            data_d = sel_dsr ? dsr_word(rdy_q, ie_q) : {8'h00, ddr_q};
        end
    end

    always_ff @(posedge i_CLK) begin
        if (i_Reset) begin
            rdy_q  <= 1'b1;
            ie_q   <= 1'b0;
            ddr_q  <= '0;
            ack_q  <= 1'b0;
            data_q <= '0;
        end else begin
            rdy_q  <= rdy_d;
            ie_q   <= ie_d;
            ddr_q  <= ddr_d;
            ack_q  <= access;
            data_q <= data_d;
        end
    end

    assign o_Ready = ack_q;
    assign o_Data  = data_q;

`ifdef LC3_CONSOLE_IE_EN
    logic int_q;

    always_ff @(posedge i_CLK) begin
        if (i_Reset) begin
            int_q <= 1'b0;
        end else begin
            int_q <= rdy_d & ie_d;
        end
    end

    assign o_INT = int_q;
`else
    assign o_INT = 1'b0;
`endif

    uart_tx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_uart_tx (
        .i_CLK  (i_CLK),
        .i_Reset(i_Reset),
        .i_Start(start),
        .i_Byte (i_MDR[7:0]),
        .o_TX   (o_TX),
        .o_Done (tx_done)
    );

endmodule

// File: tb/tb_lc3_console_tx.sv
// Scoreboard bench for lc3_console_tx: directed scenarios plus random
// accesses, checked against a cycle-indexed model of flag, frame and line.
`timescale 1ns/1ps
module tb_lc3_console_tx;

    localparam int          CPB = 4;
    localparam int          FRAME = 10 * CPB;
    localparam logic [15:0] DSR = 16'hFE04;
    localparam logic [15:0] DDR = 16'hFE06;

    logic        clk = 1'b0;
    logic        rst, mio, rw;
    logic [15:0] mar, mdr, data;
    logic        rdy, hit, tx, intr;

    lc3_console_tx #(.CLKS_PER_BIT(CPB)) dut (
        .i_CLK   (clk),
        .i_Reset (rst),
        .i_MIO_EN(mio),
        .i_R_W   (rw),
        .i_MAR   (mar),
        .i_MDR   (mdr),
        .o_Data  (data),
        .o_Ready (rdy),
        .o_Hit   (hit),
        .o_TX    (tx),
        .o_INT   (intr)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          due;
        logic        is_rd;
        logic [15:0] d;
    } exp_t;

    exp_t q[$];
    int   n_chk = 0;
    int   n_fail = 0;
    logic mon_en = 1'b0;

    // model: flag is low for cycles [busy_from, ready_at)
    int       busy_from, ready_at;
    int       frame_f, frame_cut;
    logic [7:0] frame_b, ddr_m;
    logic     ie_old, ie_new;
    int       ie_at;

    function automatic logic m_ready(int t);
        return !(t >= busy_from && t < ready_at);
    endfunction

    function automatic logic m_ie(int t);
        return (t >= ie_at) ? ie_new : ie_old;
    endfunction

    function automatic logic m_line(int t);
        int k;
        if (t < frame_f || t >= frame_f + FRAME || t >= frame_cut) return 1'b1;
        k = (t - frame_f) / CPB;
        if (k == 0) return 1'b0;
        if (k == 9) return 1'b1;
        return frame_b[k-1];
    endfunction

    function automatic logic [15:0] nohit();
        logic [15:0] a;
        do a = 16'($urandom); while (a == DSR || a == DDR);
        return a;
    endfunction

    task automatic chk(string nm, logic [15:0] act, logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            chk("tx_line", {15'b0, tx}, {15'b0, m_line(cyc)});
            chk("int", {15'b0, intr}, {15'b0, m_ie(cyc) & m_ready(cyc)});
            while (q.size() > 0 && q[0].due < cyc) begin
                e = q.pop_front();
                chk("stale_ack", 16'(e.due), 16'(cyc));
            end
            if (q.size() > 0 && q[0].due == cyc) begin
                e = q.pop_front();
                chk("ack", {15'b0, rdy}, 16'h0001);
                if (e.is_rd) chk("rdata", data, e.d);
            end else begin
                chk("no_ack", {15'b0, rdy}, 16'h0000);
                chk("idle_data", data, 16'h0000);
            end
        end
    end

    task automatic idle(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_cyc(int t);
        while (cyc < t) idle(1);
    endtask

    task automatic acc(logic w, logic [15:0] a, logic [15:0] d, logic en = 1'b1);
        int   t;
        logic h;
        exp_t e;
        t = cyc;
        mio = en;
        rw  = w;
        mar = a;
        mdr = d;
        h = (a == DSR) || (a == DDR);
        #1;
        chk("hit", {15'b0, hit}, {15'b0, h});
        if (en && h) begin
            e.due   = t + 1;
            e.is_rd = !w;
            e.d     = '0;
            if (!w) begin
                e.d = (a == DSR) ? {m_ready(t), m_ie(t), 14'b0} : {8'h00, ddr_m};
            end else if (a == DDR && m_ready(t)) begin
                busy_from = t + 1;
                ready_at  = t + 1 + FRAME;
                frame_f   = t + 1;
                frame_b   = d[7:0];
                frame_cut = 2147483647;
                ddr_m     = d[7:0];
            end
`ifdef LC3_CONSOLE_IE_EN
            else if (a == DSR) begin
                ie_old = m_ie(t);
                ie_new = d[14];
                ie_at  = t + 1;
            end
`endif
            q.push_back(e);
        end
        @(posedge clk);
        #1;
        mio = 1'b0;
        rw  = 1'b0;
        mar = '0;
    endtask

    task automatic do_reset(logic with_acc);
        int t;
        t = cyc;
        rst = 1'b1;
        if (with_acc) begin
            mio = 1'b1;
            rw  = 1'b0;
            mar = DSR;
        end
        if (ready_at > t + 1) ready_at = t + 1;
        ie_old = m_ie(t);
        ie_new = 1'b0;
        ie_at  = t + 1;
        if (frame_cut > t + 1) frame_cut = t + 1;
        ddr_m = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        mio = 1'b0;
        mar = '0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        int op;
        logic [15:0] d;
        rst = 1'b1; mio = 1'b0; rw = 1'b0; mar = '0; mdr = '0;
        busy_from = 0; ready_at = 0;
        frame_f = -1000; frame_cut = 0; frame_b = '0;
        ddr_m = '0; ie_old = 1'b0; ie_new = 1'b0; ie_at = 0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        mon_en = 1'b1;

        chk("tx_after_reset", {15'b0, tx}, 16'h0001);
        acc(1'b0, DSR, 16'h0);

        t0 = cyc;
        acc(1'b1, DDR, 16'h0041);
        idle(4);
        acc(1'b0, DSR, 16'h0);
        wait_cyc(t0 + 10);
        acc(1'b1, DDR, 16'h0042);
        acc(1'b0, DDR, 16'h0);
        wait_cyc(t0 + FRAME);
        acc(1'b1, DDR, 16'h0077);
        acc(1'b0, DSR, 16'h0);
        acc(1'b0, DDR, 16'h0);

        t0 = cyc;
        acc(1'b1, DDR, 16'h00C3);
        wait_cyc(t0 + 1 + 15);
        do_reset(1'b0);
        acc(1'b0, DSR, 16'h0);
        acc(1'b1, DDR, 16'h0055);
        idle(FRAME + 4);
        acc(1'b0, DDR, 16'h0);

        do_reset(1'b1);
        idle(2);
        acc(1'b0, 16'h3250, 16'h0);
        acc(1'b0, DSR, 16'h0, 1'b0);
        acc(1'b1, 16'h3250, 16'h00AA);

        acc(1'b1, DSR, 16'h4000);
        idle(2);
        acc(1'b1, DDR, 16'h0033);
        idle(FRAME + 4);
        acc(1'b0, DSR, 16'h0);
        acc(1'b1, DSR, 16'h0000);

        for (int i = 0; i < 300; i++) begin
            op = $urandom_range(0, 9);
            d  = 16'($urandom);
            case (op)
                0, 1: acc(1'b0, DSR, d);
                2:    acc(1'b0, DDR, d);
                3, 4: acc(1'b1, DDR, d);
                5:    acc(1'b1, DSR, d);
                6:    acc(1'($urandom_range(0, 1)), nohit(), d);
                7:    acc(1'b1, DDR, d, 1'b0);
                8:    idle($urandom_range(1, 20));
                default: begin
                    if ($urandom_range(0, 9) == 0) do_reset(1'($urandom_range(0, 1)));
                    else idle(1);
                end
            endcase
        end

        idle(FRAME + 10);
        chk("sb_drained", 16'(q.size()), 16'h0000);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/lc3_console_tx.md
LC3_CONSOLE_TX -- requirements
Module: lc3_console_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 868, clock cycles per serial bit (e.g. 100 MHz / 115200).
REQ-002 SHALL have parameter ADDR_DSR, default 16'hFE04, display status register address.
REQ-003 SHALL have parameter ADDR_DDR, default 16'hFE06, display data register address.
REQ-004 SHALL have port i_CLK  input  1  sole clock; all logic on its rising edge.
REQ-005 SHALL have port i_Reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port i_MIO_EN  input  1  memory access strobe from the datapath memory controller, one cycle per access.
REQ-007 SHALL have port i_R_W  input  1  1 = write, 0 = read; sampled with i_MIO_EN.
REQ-008 SHALL have port i_MAR  input  16  access address.
REQ-009 SHALL have port i_MDR  input  16  write data.
REQ-010 SHALL have port o_Data  output  16  read data, valid while o_Ready = 1.
REQ-011 SHALL have port o_Ready  output  1  access-complete pulse (LC3 "R" signal).
REQ-012 SHALL have port o_Hit  output  1  combinational; 1 when i_MAR equals ADDR_DSR or ADDR_DDR, so the controller deselects RAM.
REQ-013 SHALL have port o_TX  output  1  serial line, idle high.
REQ-014 SHALL have port o_INT  output  1  display interrupt request.

Function
REQ-015 SHALL respond only to accesses with i_MIO_EN = 1 and o_Hit = 1; all other accesses are ignored, with no o_Ready.
REQ-016 SHALL assert o_Ready for exactly one cycle, the cycle after the accepted access (latency 1); o_Data = 0 whenever o_Ready = 0.
REQ-017 SHALL return DSR on a read of ADDR_DSR: bit15 = ready flag, bit14 = IE (see Configuration), bits 13:0 = 0.
REQ-018 SHALL return the last written character, zero-extended, on a read of ADDR_DDR.
REQ-019 SHALL, on a write to ADDR_DDR with ready flag = 1, latch i_MDR[7:0], clear the ready flag on the next edge, and start a frame.
REQ-020 SHALL acknowledge a write to ADDR_DDR with ready flag = 0 but discard its data, leaving the frame in progress untouched.
REQ-021 SHALL use the registered ready flag for acceptance; a write in the same cycle the flag is being set is discarded.
REQ-022 SHALL implement FSM IDLE -> START -> DATA -> STOP -> IDLE, with each state bit lasting CLKS_PER_BIT cycles.
REQ-023 SHALL drive o_TX 0 in START, then 8 data bits LSB first in DATA (3-bit index, wraps 7->0 on exit), then 1 in STOP and IDLE.
REQ-024 SHALL set the ready flag on the edge that ends STOP; frame length is exactly 10*CLKS_PER_BIT cycles from the first START cycle.
REQ-025 SHALL size the baud counter to clog2(CLKS_PER_BIT) bits, counting 0..CLKS_PER_BIT-1, then wrap to 0 and advance.
REQ-026 SHALL ignore writes to ADDR_DSR except for the IE bit when enabled.

Reset
REQ-027 SHALL, on i_Reset = 1 at any edge (including mid-frame), set FSM = IDLE, o_TX = 1, ready flag = 1, IE = 0, DDR = 0, o_Ready = 0, o_Data = 0, o_INT = 0, and counters to 0.
REQ-028 SHALL drop an access presented in the same cycle as reset, with no o_Ready afterwards.

Configuration
REQ-029 SHALL, with macro LC3_CONSOLE_IE_EN defined, make DSR bit14 writable (from i_MDR[14]) and drive o_INT = ready flag AND IE as a registered output.
REQ-030 SHALL, without LC3_CONSOLE_IE_EN, read DSR bit14 as 0, ignore DSR writes entirely, and tie o_INT to 0.

Structure
REQ-031 SHALL take its FSM state encodings and the default ADDR_DSR/ADDR_DDR constants from the shared LC3 I/O package lc3_io_pkg.
REQ-032 SHALL split the serial FSM, baud counter, and shift register into sub-module uart_tx (i_CLK, i_Reset, i_Start, i_Byte[7:0], o_TX, o_Done); lc3_console_tx keeps decode, registers, and handshake.

Verification (CLKS_PER_BIT = 4)
REQ-033 SHALL check: reset, then read 16'hFE04 -> o_Ready pulses 1 cycle later with o_Data = 16'h8000; o_TX = 1.
REQ-034 SHALL check: write 16'h0041 to 16'hFE06 -> o_TX = 0,1,0,0,0,0,0,1,0,1 for 4 cycles each; DSR reads 16'h0000 during the frame and 16'h8000 after 40 cycles.
REQ-035 SHALL check: a second DDR write of 16'h0042 mid-frame -> o_Ready pulses but the line still carries 0x41, and DDR reads 16'h0041.
REQ-036 SHALL check: i_Reset pulsed at cycle 15 of a frame -> o_TX = 1 the next cycle and DSR = 16'h8000; a new write of 16'h0055 transmits cleanly.
REQ-037 SHALL check: read at 16'h3250 with i_MIO_EN = 1 -> o_Hit = 0, no o_Ready, o_Data = 0.
REQ-038 SHALL check, with LC3_CONSOLE_IE_EN: write 16'h4000 to DSR -> o_INT = 1; after a DDR write o_INT = 0 until the frame ends, then 1.
